// File: rtl/sprite_arb_pkg.sv
// Shared types for the sprite ROM arbiter.
//   arb_state_t  : arbiter FSM states (idle / burst-locked)
//   arb_tag_t    : response-tag pipeline entry {valid, requester id}
//   CONFLICT_MAX : saturation value of the optional conflict counter
package sprite_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
  } arb_tag_t;

  localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
// Picks the lowest-index valid requester at or above rr_ptr; if none, the
// lowest-index valid requester below rr_ptr (i.e. round-robin with wrap).
// Ports:
//   valid  [NUM_REQ-1:0]  request vector
//   rr_ptr [2:0]          requester with highest priority this cycle
//   grant  [NUM_REQ-1:0]  one-hot pick (all zero when nothing is valid)
//   id     [2:0]          binary index of the pick (don't-care when grant==0)
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [2:0]         rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         id
);

  logic       found_hi, found_lo;
  logic [2:0] hi_id, lo_id;

  // Two priority searches instead of a rotate: the "at or above pointer"
  // region wins over the wrapped "below pointer" region.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (valid[i] && !found_hi && (3'(i) >= rr_ptr)) begin
        found_hi = 1'b1;
        hi_id    = 3'(i);
      end
      if (valid[i] && !found_lo && (3'(i) < rr_ptr)) begin
        found_lo = 1'b1;
        lo_id    = 3'(i);
      end
    end
    id    = found_hi ? hi_id : lo_id;
    grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i] = (found_hi || found_lo) && (id == 3'(i));
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM read port between
// NUM_REQ pixel requesters using round-robin arbitration with burst locking,
// and routes ROM data back to the requester by tag after ROM_LAT cycles.
// Optional feature macro: SPRITE_ARB_STATS_EN (adds conflict_cnt).
// Ports:
//   vga_clk      clock for all logic
//   reset        synchronous, active-high
//   req_valid    per-requester read request
//   req_addr     packed addresses, requester i uses slice i
//   req_last     final beat of a burst
//   req_ready    one-hot grant (beat accepted when valid && ready)
//   rom_addr     ROM address, holds last value when nothing is granted
//   rom_q        ROM data, ROM_LAT cycles after rom_addr
//   rsp_valid    one-hot owner of rsp_data
//   rsp_data     registered ROM data
//   conflict_cnt saturating contention counter (SPRITE_ARB_STATS_EN only)
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [15:0]               conflict_cnt
`endif
);

  arb_state_t           state_q, state_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [2:0]           lock_id_q, lock_id_d;
  logic [NUM_REQ-1:0]   pick_grant, lock_mask, grant;
  logic [2:0]           pick_id, acc_id;
  logic                 accept, acc_last;
  logic [ADDR_W-1:0]    addr_hold_q, sel_addr;
  arb_tag_t             tag_q [0:ROM_LAT];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .id     (pick_id)
  );

  always_comb begin
    lock_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lock_mask[i] = (lock_id_q == 3'(i));
    end
  end

  // Next-state / grant logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    grant     = '0;
    acc_id    = lock_id_q;
    unique case (state_q)
      ARB_IDLE: begin
        grant  = pick_grant;
        acc_id = pick_id;
      end
      ARB_LOCKED: begin
        // Owner may stall mid-burst; the lock is kept and nobody else goes.
        grant = lock_mask & req_valid;
      end
    endcase
    accept   = |grant;
    acc_last = |(grant & req_last);
    if (accept) begin
      if (acc_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (acc_id == 3'(NUM_REQ - 1)) ? 3'd0 : acc_id + 3'd1;
      end else begin
        state_d   = ARB_LOCKED;
        lock_id_d = acc_id;
      end
    end
  end

  always_comb begin
    sel_addr = addr_hold_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign req_ready = grant;
  assign rom_addr  = sel_addr;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      addr_hold_q <= '0;
      rsp_data    <= '0;
      for (int unsigned k = 0; k <= ROM_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      addr_hold_q <= sel_addr;
      tag_q[0]    <= '{vld: accept, id: acc_id};
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      // Stage ROM_LAT-1 lines up with rom_q for the same beat.
      if (tag_q[ROM_LAT-1].vld) rsp_data <= rom_q;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_q[ROM_LAT].vld && (tag_q[ROM_LAT].id == 3'(i));
    end
  end

`ifdef SPRITE_ARB_STATS_EN
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  logic multi_req, lock_block;

  // v & (v-1) is non-zero exactly when more than one bit is set.
  assign multi_req  = |(req_valid & (req_valid - ONE));
  assign lock_block = (state_q == ARB_LOCKED) && |(req_valid & ~lock_mask);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if ((multi_req || lock_block) && (conflict_cnt != CONFLICT_MAX)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;
  localparam int NR  = 4;
  localparam int AW  = 10;
  localparam int DW  = 4;
  localparam int LAT = 1;

  logic             vga_clk = 1'b0;
  logic             reset   = 1'b1;
  logic [NR-1:0]    req_valid = '0, req_last = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [AW-1:0]    rom_addr;
  logic [DW-1:0]    rom_q = '0, rsp_data;
`ifdef SPRITE_ARB_STATS_EN
  logic [15:0]      conflict_cnt;
`endif

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_last  (req_last),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  // ROM contents model: any fixed address->data mapping will do.
  function automatic logic [3:0] romf(input logic [9:0] a);
    return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
  endfunction

  always @(posedge vga_clk) rom_q <= romf(rom_addr);

  int passed = 0, total = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: owner of the current burst (-1 = none), round-robin start,
  // last driven address, and a queue of responses with their due cycle.
  typedef struct {int id; logic [3:0] data; int due;} rsp_t;
  rsp_t        rq[$];
  int          owner = -1, rr = 0;
  logic [9:0]  last_addr = '0;
  int unsigned cnt_m = 0;

  function automatic int model_pick();
    if (owner >= 0) return req_valid[owner] ? owner : -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (rr + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: sample mid-cycle, compare with the model, advance the model.
  task automatic step(input bit presampled = 1'b0);
    int g;
    logic [NR-1:0] eg, er;
    logic [9:0] ea;
    logic [3:0] ed;
    bit has;
    if (!presampled) #4;
    g  = model_pick();
    eg = (g >= 0) ? (NR'(1) << g) : '0;
    ea = (g >= 0) ? req_addr[g*AW +: AW] : last_addr;
    er = '0; ed = '0; has = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      er  = NR'(1) << rq[0].id;
      ed  = rq[0].data;
      has = 1'b1;
      void'(rq.pop_front());
    end
    check("req_ready", req_ready, eg);
    check("rom_addr", rom_addr, ea);
    check("rsp_valid", rsp_valid, er);
    if (has) check("rsp_data", rsp_data, ed);
`ifdef SPRITE_ARB_STATS_EN
    check("conflict_cnt", conflict_cnt, cnt_m);
`endif
    if (($countones(req_valid) > 1 ||
         (owner >= 0 && (req_valid & ~(NR'(1) << owner)) != '0)) && cnt_m < 32'hFFFF)
      cnt_m++;
    if (g >= 0) begin
      rq.push_back('{g, romf(ea), cyc + LAT + 1});
      last_addr = ea;
      if (req_last[g]) begin
        owner = -1;
        rr    = (g + 1) % NR;
      end else begin
        owner = g;
      end
    end
    @(posedge vga_clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    @(posedge vga_clk); #1;
    cyc++;
    reset     = 1'b0;
    owner     = -1;
    rr        = 0;
    last_addr = '0;
    cnt_m     = 0;
    rq.delete();
  endtask

  typedef struct {logic [3:0] v; logic [3:0] l; logic [3:0] r;} vec_t;
  vec_t tbl[13];

  initial begin
    tbl = '{
      '{4'b0100, 4'b1111, 4'b0100},
      '{4'b1111, 4'b1111, 4'b1000},
      '{4'b1111, 4'b1111, 4'b0001},
      '{4'b0110, 4'b0000, 4'b0010},
      '{4'b0101, 4'b0000, 4'b0000},
      '{4'b0111, 4'b0000, 4'b0010},
      '{4'b0111, 4'b0010, 4'b0010},
      '{4'b0111, 4'b1111, 4'b0100},
      '{4'b0011, 4'b1111, 4'b0001},
      '{4'b0000, 4'b1111, 4'b0000},
      '{4'b1001, 4'b0000, 4'b1000},
      '{4'b1001, 4'b1000, 4'b1000},
      '{4'b1001, 4'b1111, 4'b0001}
    };

    // Reset state
    do_reset();
    do_reset();
    #4;
    check("reset_ready", req_ready, 4'b0000);
    check("reset_rom_addr", rom_addr, 10'h000);
    check("reset_rsp_valid", rsp_valid, 4'b0000);
    step(1'b1);

    // Single request, two-cycle response
    req_valid = 4'b0100;
    req_last  = 4'b1111;
    req_addr[2*AW +: AW] = 10'h025;
    #4;
    check("t1_ready", req_ready, 4'b0100);
    check("t1_rom_addr", rom_addr, 10'h025);
    step(1'b1);
    req_valid = '0;
    step();
    #4;
    check("t1_rsp_valid", rsp_valid, 4'b0100);
    check("t1_rsp_data", rsp_data, romf(10'h025));
    step(1'b1);

    // Table-driven sequence from reset
    do_reset();
    req_addr = {10'h103, 10'h102, 10'h101, 10'h100};
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].v;
      req_last  = tbl[i].l;
      #4;
      check("tbl_ready", req_ready, tbl[i].r);
      step(1'b1);
    end
    req_valid = '0;
    repeat (3) step();

    // Four single-beat requesters rotate with no bubbles
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #4;
      check("rr_order", req_ready, 4'b0001 << (k % 4));
      step(1'b1);
    end
    req_valid = '0;
    repeat (3) step();

    // 32-beat burst from req 1 while req 0 and req 3 wait
    do_reset();
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    step();
    req_valid = 4'b1011;
    for (int b = 2; b <= 32; b++) begin
      req_last = (b == 32) ? 4'b0010 : 4'b0000;
      #4;
      check("burst_ready", req_ready, 4'b0010);
      step(1'b1);
    end
    req_last = 4'b1111;
    #4;
    check("after_burst_1", req_ready, 4'b1000);
    step(1'b1);
    #4;
    check("after_burst_2", req_ready, 4'b0001);
    step(1'b1);
    req_valid = '0;
    repeat (3) step();

    // Reset in the middle of a burst drops in-flight responses
    do_reset();
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    repeat (3) step();
    do_reset();
    req_valid = 4'b0110;
    req_last  = 4'b1111;
    #4;
    check("post_reset_grant", req_ready, 4'b0010);
    check("post_reset_rsp", rsp_valid, 4'b0000);
    step(1'b1);
    req_valid = '0;
    repeat (3) step();

    // Lock owner stalls for two cycles while req 2 waits
    do_reset();
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    step();
    req_valid = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      #4;
      check("stall_ready", req_ready, 4'b0000);
      step(1'b1);
    end
    req_valid = 4'b0101;
    #4;
    check("resume_ready", req_ready, 4'b0001);
    step(1'b1);
    req_last = 4'b0001;
    #4;
    check("resume_last", req_ready, 4'b0001);
    step(1'b1);
    #4;
    check("after_stall", req_ready, 4'b0100);
    step(1'b1);
    req_valid = '0;
    repeat (3) step();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      req_valid = NR'($urandom);
      req_last  = NR'($urandom & $urandom);
      req_addr  = {AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)};
      step();
    end
    req_valid = '0;
    repeat (3) step();

`ifdef SPRITE_ARB_STATS_EN
    // Counter saturation under sustained contention
    do_reset();
    req_valid = 4'b0011;
    req_last  = 4'b1111;
    repeat (70000) @(posedge vga_clk);
    #5;
    check("conflict_sat", conflict_cnt, 16'hFFFF);
    #1;
    do_reset();
    #4;
    check("conflict_reset", conflict_cnt, 16'h0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
